// File: rtl/data_mem_responder.sv
// Responder end of the processor data-memory valid/ready port: word-addressed array with fixed
// per-op wait states. Define DATA_MEM_RESPONDER_PERF_CNT_EN to add saturating read/write counters.
module data_mem_responder #(
  parameter int unsigned BW_PROCESSOR_DATA = 32,
  parameter int unsigned BW_ADDRESS        = 32,
  parameter int unsigned DEPTH_LOG2        = 10,
  parameter int unsigned READ_LATENCY      = 2,
  parameter int unsigned WRITE_LATENCY     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_mem_valid,
  output logic                         i_mem_ready,
  input  logic                         i_mem_r0w1,
  input  logic [BW_ADDRESS-1:0]        i_mem_rwaddr,
  input  logic [BW_PROCESSOR_DATA-1:0] i_mem_wdata,
  output logic [BW_PROCESSOR_DATA-1:0] i_mem_rdata,
  output logic                         o_oob_err
`ifdef DATA_MEM_RESPONDER_PERF_CNT_EN
  ,
  output logic [31:0]                  o_rd_cnt,
  output logic [31:0]                  o_wr_cnt
`endif
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [3:0]  RdLat = 4'(READ_LATENCY);
  localparam logic [3:0]  WrLat = 4'(WRITE_LATENCY);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic                         op_w_q;
  logic                         oob_q;
  logic [DEPTH_LOG2-1:0]        idx_q;
  logic [BW_PROCESSOR_DATA-1:0] wdata_q;
  logic                         oob_err_q;
  logic                         latch;
  logic                         oob_in;
  logic [3:0]                   lat_sel;
  logic                         unused_addr;

  logic [BW_PROCESSOR_DATA-1:0] mem_q [Depth];

  assign oob_in      = |i_mem_rwaddr[BW_ADDRESS-1:DEPTH_LOG2+2];
  assign lat_sel     = i_mem_r0w1 ? WrLat : RdLat;
  assign unused_addr = ^i_mem_rwaddr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_mem_valid) begin
          latch   = 1'b1;
          cnt_d   = lat_sel - 4'd1;
          state_d = (lat_sel == 4'd1) ? StDone : StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      op_w_q    <= 1'b0;
      oob_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      oob_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        op_w_q  <= i_mem_r0w1;
        oob_q   <= oob_in;
        idx_q   <= i_mem_rwaddr[DEPTH_LOG2+1:2];
        wdata_q <= i_mem_wdata;
        if (oob_in) oob_err_q <= 1'b1;
      end
    end
  end

  // Array has no reset; a reset during DONE leaves state_q at IDLE so the write is never committed.
  always_ff @(posedge clk) begin
    if (state_q == StDone && op_w_q && !oob_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    i_mem_ready = (state_q == StDone);
    i_mem_rdata = '0;
    if (state_q == StDone && !op_w_q && !oob_q) begin
      i_mem_rdata = mem_q[idx_q];
    end
  end

  assign o_oob_err = oob_err_q;

`ifdef DATA_MEM_RESPONDER_PERF_CNT_EN
  logic        hs;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  assign hs = i_mem_valid && i_mem_ready;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (hs && !op_w_q && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_d = rd_cnt_q + 32'd1;
    if (hs && op_w_q && wr_cnt_q != 32'hFFFF_FFFF)  wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign o_rd_cnt = rd_cnt_q;
  assign o_wr_cnt = wr_cnt_q;
`endif

endmodule
